// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter over three register-bank writers (ALU, load, mul/div) with a pending-write scoreboard.
// One write per cycle with one cycle of latency to the bank; hazard is combinational from the registered busy mask.
module regfile_write_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [4:0]  req_reg_0,
  input  logic [4:0]  req_reg_1,
  input  logic [4:0]  req_reg_2,
  input  logic [31:0] req_data_0,
  input  logic [31:0] req_data_1,
  input  logic [31:0] req_data_2,
  output logic [2:0]  req_ready,
  output logic        regWrite,
  output logic [4:0]  writeRegister,
  output logic [31:0] writeData,
  input  logic        reserve_valid,
  input  logic [4:0]  reserve_reg,
  input  logic [4:0]  check_reg1,
  input  logic [4:0]  check_reg2,
  output logic        hazard,
  output logic [31:0] busy_mask
);

  logic [1:0]  last_grant;
  logic [1:0]  grant_idx;
  logic        xfer;
  logic [4:0]  sel_reg;
  logic [31:0] sel_data;
  logic [31:0] busy_next;

  // Search order starts one past the last winner and wraps modulo 3.
  always_comb begin
    req_ready = 3'b000;
    if (!reset) begin
      case (last_grant)
        2'd0: begin
          if (req_valid[1])      req_ready = 3'b010;
          else if (req_valid[2]) req_ready = 3'b100;
          else if (req_valid[0]) req_ready = 3'b001;
        end
        2'd1: begin
          if (req_valid[2])      req_ready = 3'b100;
          else if (req_valid[0]) req_ready = 3'b001;
          else if (req_valid[1]) req_ready = 3'b010;
        end
        default: begin
          if (req_valid[0])      req_ready = 3'b001;
          else if (req_valid[1]) req_ready = 3'b010;
          else if (req_valid[2]) req_ready = 3'b100;
        end
      endcase
    end
  end

  assign xfer = |(req_valid & req_ready);

  always_comb begin
    grant_idx = 2'd0;
    sel_reg   = req_reg_0;
    sel_data  = req_data_0;
    if (req_ready[1]) begin
      grant_idx = 2'd1;
      sel_reg   = req_reg_1;
      sel_data  = req_data_1;
    end else if (req_ready[2]) begin
      grant_idx = 2'd2;
      sel_reg   = req_reg_2;
      sel_data  = req_data_2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant    <= 2'd2;
      regWrite      <= 1'b0;
      writeRegister <= 5'd0;
      writeData     <= 32'd0;
    end else begin
      regWrite <= 1'b0;
      if (xfer) begin
        last_grant    <= grant_idx;
        // Writes to r0 are accepted from the requester but never reach the bank.
        regWrite      <= (sel_reg != 5'd0);
        writeRegister <= sel_reg;
        writeData     <= sel_data;
      end
    end
  end

  // Clear on the bank write, then set on reserve so a same-cycle reserve wins.
  always_comb begin
    busy_next = busy_mask;
    if (regWrite)
      busy_next[writeRegister] = 1'b0;
    if (reserve_valid && (reserve_reg != 5'd0))
      busy_next[reserve_reg] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset)
      busy_mask <= 32'd0;
    else
      busy_mask <= busy_next;
  end

  assign hazard = busy_mask[check_reg1] | busy_mask[check_reg2];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: grant rotation, r0 writes, scoreboard and reset behaviour.
module tb_regfile_write_arbiter;

  logic        clock;
  logic        reset;
  logic [2:0]  req_valid;
  logic [4:0]  req_reg_0, req_reg_1, req_reg_2;
  logic [31:0] req_data_0, req_data_1, req_data_2;
  logic [2:0]  req_ready;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic        reserve_valid;
  logic [4:0]  reserve_reg;
  logic [4:0]  check_reg1, check_reg2;
  logic        hazard;
  logic [31:0] busy_mask;

  int errors = 0;
  int checks = 0;

  regfile_write_arbiter dut (
    .clock(clock), .reset(reset), .req_valid(req_valid),
    .req_reg_0(req_reg_0), .req_reg_1(req_reg_1), .req_reg_2(req_reg_2),
    .req_data_0(req_data_0), .req_data_1(req_data_1), .req_data_2(req_data_2),
    .req_ready(req_ready), .regWrite(regWrite), .writeRegister(writeRegister),
    .writeData(writeData), .reserve_valid(reserve_valid), .reserve_reg(reserve_reg),
    .check_reg1(check_reg1), .check_reg2(check_reg2), .hazard(hazard),
    .busy_mask(busy_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 3'b111;
    req_reg_0 = 5'd5;  req_reg_1 = 5'd6;  req_reg_2 = 5'd7;
    req_data_0 = 32'hA; req_data_1 = 32'hB; req_data_2 = 32'hC;
    reserve_valid = 1'b0; reserve_reg = 5'd0;
    check_reg1 = 5'd0; check_reg2 = 5'd0;
    #1;
    chk("ready_in_reset", {29'd0, req_ready}, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_regWrite", {31'd0, regWrite}, 32'h0);
    chk("rst_wreg", {27'd0, writeRegister}, 32'h0);
    chk("rst_wdata", writeData, 32'h0);
    chk("rst_busy", busy_mask, 32'h0);
    chk("rr_ready0", {29'd0, req_ready}, 32'h1);

    // Round-robin rotation with all three requesters held valid.
    tick();
    chk("rr_we1", {31'd0, regWrite}, 32'h1);
    chk("rr_reg1", {27'd0, writeRegister}, 32'd5);
    chk("rr_data1", writeData, 32'hA);
    chk("rr_ready1", {29'd0, req_ready}, 32'h2);
    tick();
    chk("rr_reg2", {27'd0, writeRegister}, 32'd6);
    chk("rr_data2", writeData, 32'hB);
    chk("rr_ready2", {29'd0, req_ready}, 32'h4);
    tick();
    chk("rr_reg3", {27'd0, writeRegister}, 32'd7);
    chk("rr_data3", writeData, 32'hC);
    chk("rr_ready3", {29'd0, req_ready}, 32'h1);
    tick();
    chk("rr_reg4", {27'd0, writeRegister}, 32'd5);
    chk("rr_ready4", {29'd0, req_ready}, 32'h2);
    req_valid = 3'b000;
    #1;
    chk("idle_ready", {29'd0, req_ready}, 32'h0);
    tick();
    chk("idle_we", {31'd0, regWrite}, 32'h0);
    chk("idle_hold_reg", {27'd0, writeRegister}, 32'd5);
    chk("idle_hold_data", writeData, 32'hA);

    // Write to r0 from the load unit: consumed but not written.
    req_valid = 3'b010; req_reg_1 = 5'd0; req_data_1 = 32'hFFFF_FFFF;
    #1;
    chk("r0_ready", {29'd0, req_ready}, 32'h2);
    tick();
    req_valid = 3'b000;
    chk("r0_we", {31'd0, regWrite}, 32'h0);

    // Scoreboard: reserve r9, hazard until the write lands.
    reserve_valid = 1'b1; reserve_reg = 5'd9; check_reg1 = 5'd9;
    #1;
    chk("hz_no_bypass", {31'd0, hazard}, 32'h0);
    tick();
    reserve_valid = 1'b0;
    #1;
    chk("hz_set", {31'd0, hazard}, 32'h1);
    chk("busy_r9", busy_mask, 32'h0000_0200);
    req_valid = 3'b001; req_reg_0 = 5'd9; req_data_0 = 32'h99;
    #1;
    chk("alu_ready", {29'd0, req_ready}, 32'h1);
    tick();
    req_valid = 3'b000;
    #1;
    chk("r9_we", {31'd0, regWrite}, 32'h1);
    chk("r9_data", writeData, 32'h99);
    chk("hz_during_we", {31'd0, hazard}, 32'h1);
    tick();
    chk("hz_cleared", {31'd0, hazard}, 32'h0);
    chk("busy_clr", busy_mask, 32'h0);

    // Reserve and bank write hitting r12 in the same cycle: reserve wins.
    reserve_valid = 1'b1; reserve_reg = 5'd12;
    tick();
    reserve_valid = 1'b0;
    req_valid = 3'b001; req_reg_0 = 5'd12; req_data_0 = 32'h12;
    #1;
    chk("r12_ready", {29'd0, req_ready}, 32'h1);
    tick();
    req_valid = 3'b000;
    reserve_valid = 1'b1; reserve_reg = 5'd12;
    #1;
    chk("r12_we", {31'd0, regWrite}, 32'h1);
    tick();
    reserve_valid = 1'b0;
    #1;
    chk("r12_set_wins", busy_mask, 32'h0000_1000);

    // Reserve of r0 is ignored; r0 never reports a hazard.
    reserve_valid = 1'b1; reserve_reg = 5'd0; check_reg1 = 5'd0; check_reg2 = 5'd0;
    tick();
    reserve_valid = 1'b0;
    #1;
    chk("r0_hazard", {31'd0, hazard}, 32'h0);
    chk("r0_busy", busy_mask, 32'h0000_1000);
    check_reg2 = 5'd12;
    #1;
    chk("hz_check2", {31'd0, hazard}, 32'h1);

    // Reset while the mul/div unit requests: nothing transferred, grant restarts at 0.
    req_valid = 3'b100; req_reg_2 = 5'd20; req_data_2 = 32'h20;
    reset = 1'b1;
    #1;
    chk("rst_mid_ready", {29'd0, req_ready}, 32'h0);
    tick();
    reset = 1'b0;
    req_valid = 3'b111;
    req_reg_0 = 5'd5; req_data_0 = 32'hA;
    #1;
    chk("rst_mid_we", {31'd0, regWrite}, 32'h0);
    chk("rst_mid_busy", busy_mask, 32'h0);
    chk("rst_mid_ready0", {29'd0, req_ready}, 32'h1);
    tick();
    req_valid = 3'b000;
    #1;
    chk("post_rst_we", {31'd0, regWrite}, 32'h1);
    chk("post_rst_reg", {27'd0, writeRegister}, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
